// File: rtl/cpu_defs_pkg.sv
// Shared encodings for the pipeline control path: next-PC select,
// exception codes, the exception vector and the JR decode fields.
package cpu_defs;

    typedef enum logic [3:0] {
        PC_SEQ  = 4'd0,
        PC_J    = 4'd1,
        PC_JR   = 4'd2,
        PC_CORR = 4'd3,
        PC_VEC  = 4'd4,
        PC_EPC  = 4'd5
    } pc_src_t;

    localparam logic [31:0] VEC_EXC    = 32'h8000_0180;
    localparam logic [4:0]  EXC_INT    = 5'd0;
    localparam logic [4:0]  EXC_SYS    = 5'd8;
    localparam logic [5:0]  OP_SPECIAL = 6'd0;
    localparam logic [5:0]  FUNCT_JR   = 6'b001000;

    function automatic logic is_jr(input logic [31:0] ir);
        return (ir[31:26] == OP_SPECIAL) && (ir[5:0] == FUNCT_JR);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Pure-combinational hazard decode: load-use dependency, branch
// misprediction and JR-in-ID detection.
module hazard_detect
    import cpu_defs::*;
(
    input  logic [31:0] id_ir,
    input  logic [4:0]  ifid_rs_addr,
    input  logic [4:0]  real_rt_addr,
    input  logic [4:0]  idex_rd_addr,
    input  logic        idex_mem_read,
    input  logic [31:0] predicted_idex_pc,
    input  logic [31:0] target_exmem_pc,
    output logic        load_use,
    output logic        mispredict,
    output logic        jr
);

    // $0 never carries a real dependency, so a load into it cannot stall.
    assign load_use = idex_mem_read && (idex_rd_addr != 5'd0) &&
                      ((idex_rd_addr == ifid_rs_addr) || (idex_rd_addr == real_rt_addr));

    assign mispredict = (predicted_idex_pc != target_exmem_pc);
    assign jr         = is_jr(id_ir);

endmodule

// File: rtl/control_unit.sv
// Pipeline hazard/exception controller: strict-priority response mux plus
// a single flop that remembers an interrupt that could not be taken yet.
module control_unit
    import cpu_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] id_ir,
    input  logic        mem_stall,
    input  logic [4:0]  ifid_rs_addr,
    input  logic [4:0]  real_rt_addr,
    input  logic [4:0]  idex_rd_addr,
    input  logic        idex_mem_read,
    input  logic [31:0] predicted_idex_pc,
    input  logic [31:0] target_exmem_pc,
    input  logic        cp0_intr,
    input  logic        id_jump,
    input  logic        exmem_eret,
    input  logic        exmem_syscall,
    output logic [3:0]  cu_pc_src,
    output logic        cu_pc_stall,
    output logic        cu_ifid_stall,
    output logic        cu_idex_stall,
    output logic        cu_exmem_stall,
    output logic        cu_ifid_flush,
    output logic        cu_idex_flush,
    output logic        cu_exmem_flush,
    output logic        cu_cp0_w_en,
    output logic [4:0]  cu_exec_code,
    output logic [31:0] cu_epc,
    output logic [31:0] cu_vector,
    output logic        bpu_write_en
);

    logic    load_use;
    logic    mispredict;
    logic    jr;
    logic    intr_pending;
    logic    intr;
    logic    intr_take;
    pc_src_t pc_src;

    hazard_detect u_hazard_detect (
        .id_ir             (id_ir),
        .ifid_rs_addr      (ifid_rs_addr),
        .real_rt_addr      (real_rt_addr),
        .idex_rd_addr      (idex_rd_addr),
        .idex_mem_read     (idex_mem_read),
        .predicted_idex_pc (predicted_idex_pc),
        .target_exmem_pc   (target_exmem_pc),
        .load_use          (load_use),
        .mispredict        (mispredict),
        .jr                (jr)
    );

    assign intr      = cp0_intr || intr_pending;
    assign cu_epc    = target_exmem_pc;
    assign cu_vector = VEC_EXC;
    assign cu_pc_src = pc_src;

    always_comb begin
        // NOTE: every output gets a default before the priority chain so no
        // path leaves a signal unassigned and no latch is inferred.
        pc_src         = PC_SEQ;
        cu_pc_stall    = 1'b0;
        cu_ifid_stall  = 1'b0;
        cu_idex_stall  = 1'b0;
        cu_exmem_stall = 1'b0;
        cu_ifid_flush  = 1'b0;
        cu_idex_flush  = 1'b0;
        cu_exmem_flush = 1'b0;
        cu_cp0_w_en    = 1'b0;
        cu_exec_code   = 5'd0;
        bpu_write_en   = 1'b0;
        intr_take      = 1'b0;

        if (rst) begin
            // reset holds every control inactive
        end else if (mem_stall) begin
            cu_pc_stall    = 1'b1;
            cu_ifid_stall  = 1'b1;
            cu_idex_stall  = 1'b1;
            cu_exmem_stall = 1'b1;
        end else if (exmem_syscall || intr) begin
            pc_src         = PC_VEC;
            cu_ifid_flush  = 1'b1;
            cu_idex_flush  = 1'b1;
            cu_exmem_flush = 1'b1;
            cu_cp0_w_en    = 1'b1;
            cu_exec_code   = exmem_syscall ? EXC_SYS : EXC_INT;
            intr_take      = !exmem_syscall;
        end else if (exmem_eret) begin
            pc_src         = PC_EPC;
            cu_ifid_flush  = 1'b1;
            cu_idex_flush  = 1'b1;
            cu_exmem_flush = 1'b1;
        end else if (mispredict) begin
            pc_src         = PC_CORR;
            cu_ifid_flush  = 1'b1;
            cu_idex_flush  = 1'b1;
            bpu_write_en   = 1'b1;
        end else if (load_use) begin
            cu_pc_stall    = 1'b1;
            cu_ifid_stall  = 1'b1;
            cu_idex_flush  = 1'b1;
        end else if (id_jump) begin
            pc_src         = PC_J;
            cu_ifid_flush  = 1'b1;
        end else if (jr) begin
            pc_src         = PC_JR;
            cu_ifid_flush  = 1'b1;
        end
    end

    // An interrupt blocked by a stall or a syscall stays pending until taken.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state updates use non-blocking assignments; the async reset
        // clears the pending flag without waiting for a clock edge.
        if (rst) begin
            intr_pending <= 1'b0;
        end else if (intr_take) begin
            intr_pending <= 1'b0;
        end else if (cp0_intr) begin
            intr_pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a table of single-cycle vectors
// plus hand-written multi-cycle sequences, checked through a scoreboard queue.
module tb_control_unit;

    typedef struct packed {
        logic        mem_stall;
        logic [31:0] id_ir;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        mem_read;
        logic [31:0] pred_pc;
        logic [31:0] tgt_pc;
        logic        cp0_intr;
        logic        jump;
        logic        eret;
        logic        syscall;
    } in_t;

    // stall = {pc, ifid, idex, exmem}; flush = {ifid, idex, exmem}
    typedef struct packed {
        logic [3:0]  pc_src;
        logic [3:0]  stall;
        logic [2:0]  flush;
        logic        cp0_w_en;
        logic [4:0]  exec_code;
        logic [31:0] epc;
        logic [31:0] vector;
        logic        bpu;
    } out_t;

    typedef struct {
        string name;
        in_t   inp;
        out_t  exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] id_ir;
    logic        mem_stall;
    logic [4:0]  ifid_rs_addr;
    logic [4:0]  real_rt_addr;
    logic [4:0]  idex_rd_addr;
    logic        idex_mem_read;
    logic [31:0] predicted_idex_pc;
    logic [31:0] target_exmem_pc;
    logic        cp0_intr;
    logic        id_jump;
    logic        exmem_eret;
    logic        exmem_syscall;
    logic [3:0]  cu_pc_src;
    logic        cu_pc_stall;
    logic        cu_ifid_stall;
    logic        cu_idex_stall;
    logic        cu_exmem_stall;
    logic        cu_ifid_flush;
    logic        cu_idex_flush;
    logic        cu_exmem_flush;
    logic        cu_cp0_w_en;
    logic [4:0]  cu_exec_code;
    logic [31:0] cu_epc;
    logic [31:0] cu_vector;
    logic        bpu_write_en;

    int   n_applied = 0;
    int   n_miss    = 0;
    out_t exp_q[$];
    vec_t vecs[$];

    localparam logic [31:0] VEC = 32'h8000_0180;

    always #5 clk = ~clk;

    control_unit dut (
        .clk               (clk),
        .rst               (rst),
        .id_ir             (id_ir),
        .mem_stall         (mem_stall),
        .ifid_rs_addr      (ifid_rs_addr),
        .real_rt_addr      (real_rt_addr),
        .idex_rd_addr      (idex_rd_addr),
        .idex_mem_read     (idex_mem_read),
        .predicted_idex_pc (predicted_idex_pc),
        .target_exmem_pc   (target_exmem_pc),
        .cp0_intr          (cp0_intr),
        .id_jump           (id_jump),
        .exmem_eret        (exmem_eret),
        .exmem_syscall     (exmem_syscall),
        .cu_pc_src         (cu_pc_src),
        .cu_pc_stall       (cu_pc_stall),
        .cu_ifid_stall     (cu_ifid_stall),
        .cu_idex_stall     (cu_idex_stall),
        .cu_exmem_stall    (cu_exmem_stall),
        .cu_ifid_flush     (cu_ifid_flush),
        .cu_idex_flush     (cu_idex_flush),
        .cu_exmem_flush    (cu_exmem_flush),
        .cu_cp0_w_en       (cu_cp0_w_en),
        .cu_exec_code      (cu_exec_code),
        .cu_epc            (cu_epc),
        .cu_vector         (cu_vector),
        .bpu_write_en      (bpu_write_en)
    );

    function automatic in_t in_idle();
        in_t t;
        t          = '0;
        t.id_ir    = 32'h0000_0020;
        t.pred_pc  = 32'h0040_0010;
        t.tgt_pc   = 32'h0040_0010;
        return t;
    endfunction

    function automatic out_t mk_out(input logic [3:0] src, input logic [3:0] stall,
                                    input logic [2:0] flush, input logic w,
                                    input logic [4:0] code, input logic bpu,
                                    input logic [31:0] epc);
        out_t o;
        o.pc_src    = src;
        o.stall     = stall;
        o.flush     = flush;
        o.cp0_w_en  = w;
        o.exec_code = code;
        o.epc       = epc;
        o.vector    = VEC;
        o.bpu       = bpu;
        return o;
    endfunction

    task automatic add(input string name, input in_t t, input out_t e);
        vec_t v;
        v.name = name;
        v.inp  = t;
        v.exp  = e;
        vecs.push_back(v);
    endtask

    task automatic drive(input in_t t, input out_t e);
        mem_stall         = t.mem_stall;
        id_ir             = t.id_ir;
        ifid_rs_addr      = t.rs;
        real_rt_addr      = t.rt;
        idex_rd_addr      = t.rd;
        idex_mem_read     = t.mem_read;
        predicted_idex_pc = t.pred_pc;
        target_exmem_pc   = t.tgt_pc;
        cp0_intr          = t.cp0_intr;
        id_jump           = t.jump;
        exmem_eret        = t.eret;
        exmem_syscall     = t.syscall;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name);
        out_t act;
        out_t e;
        act.pc_src    = cu_pc_src;
        act.stall     = {cu_pc_stall, cu_ifid_stall, cu_idex_stall, cu_exmem_stall};
        act.flush     = {cu_ifid_flush, cu_idex_flush, cu_exmem_flush};
        act.cp0_w_en  = cu_cp0_w_en;
        act.exec_code = cu_exec_code;
        act.epc       = cu_epc;
        act.vector    = cu_vector;
        act.bpu       = bpu_write_en;
        n_applied++;
        if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL %s: no expected entry in scoreboard", name);
            return;
        end
        e = exp_q.pop_front();
        if (act !== e) begin
            n_miss++;
            $display("FAIL %s: got src=%0d stall=%b flush=%b w=%b code=%0d epc=%h vec=%h bpu=%b, want src=%0d stall=%b flush=%b w=%b code=%0d epc=%h vec=%h bpu=%b",
                     name, act.pc_src, act.stall, act.flush, act.cp0_w_en, act.exec_code,
                     act.epc, act.vector, act.bpu, e.pc_src, e.stall, e.flush, e.cp0_w_en,
                     e.exec_code, e.epc, e.vector, e.bpu);
        end
    endtask

    // One clocked step: drive after the edge, sample mid-cycle.
    task automatic step(input string name, input in_t t, input out_t e);
        @(posedge clk);
        #1;
        drive(t, e);
        @(negedge clk);
        check(name);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1, "timeout");
    end

    initial begin
        in_t  t;
        out_t none;

        // Reset with active hazards: everything must read inactive.
        rst = 1'b1;
        t = in_idle();
        t.tgt_pc   = 32'h0040_0100;
        t.cp0_intr = 1'b1;
        t.jump     = 1'b1;
        drive(t, mk_out(4'd0, 4'b0000, 3'b000, 1'b0, 5'd0, 1'b0, 32'h0040_0100));
        #2;
        check("reset_outputs");
        drive(in_idle(), mk_out(4'd0, 4'b0000, 3'b000, 1'b0, 5'd0, 1'b0, 32'h0040_0010));
        #1;
        rst = 1'b0;
        #1;
        check("after_reset_idle");

        none = mk_out(4'd0, 4'b0000, 3'b000, 1'b0, 5'd0, 1'b0, 32'h0040_0010);

        t = in_idle();
        add("idle", t, none);
        t = in_idle(); t.mem_read = 1; t.rd = 5'd16; t.rs = 5'd16;
        add("load_use_rs", t, mk_out(4'd0, 4'b1100, 3'b010, 0, 5'd0, 0, t.tgt_pc));
        t = in_idle(); t.mem_read = 1; t.rd = 5'd16; t.rt = 5'd16;
        add("load_use_rt", t, mk_out(4'd0, 4'b1100, 3'b010, 0, 5'd0, 0, t.tgt_pc));
        t = in_idle(); t.mem_read = 1; t.rd = 5'd0;
        add("load_rd_zero", t, none);
        t = in_idle(); t.mem_read = 0; t.rd = 5'd16; t.rs = 5'd16;
        add("no_load_match", t, none);
        t = in_idle(); t.tgt_pc = 32'h0040_0100;
        add("mispredict", t, mk_out(4'd3, 4'b0000, 3'b110, 0, 5'd0, 1, t.tgt_pc));
        t = in_idle(); t.jump = 1;
        add("jump", t, mk_out(4'd1, 4'b0000, 3'b100, 0, 5'd0, 0, t.tgt_pc));
        t = in_idle(); t.id_ir = 32'h03E0_0008;
        add("jr", t, mk_out(4'd2, 4'b0000, 3'b100, 0, 5'd0, 0, t.tgt_pc));
        t = in_idle(); t.id_ir = 32'h03E0_F809;
        add("jalr_not_jr", t, none);
        t = in_idle(); t.id_ir = 32'h03E0_0008; t.jump = 1;
        add("jump_over_jr", t, mk_out(4'd1, 4'b0000, 3'b100, 0, 5'd0, 0, t.tgt_pc));
        t = in_idle(); t.eret = 1;
        add("eret", t, mk_out(4'd5, 4'b0000, 3'b111, 0, 5'd0, 0, t.tgt_pc));
        t = in_idle(); t.syscall = 1; t.tgt_pc = 32'h0040_0020;
        add("syscall", t, mk_out(4'd4, 4'b0000, 3'b111, 1, 5'd8, 0, t.tgt_pc));
        t = in_idle(); t.cp0_intr = 1; t.tgt_pc = 32'h0040_0030;
        add("intr_direct", t, mk_out(4'd4, 4'b0000, 3'b111, 1, 5'd0, 0, t.tgt_pc));
        t = in_idle(); t.syscall = 1; t.eret = 1;
        add("syscall_over_eret", t, mk_out(4'd4, 4'b0000, 3'b111, 1, 5'd8, 0, t.tgt_pc));
        t = in_idle(); t.eret = 1; t.tgt_pc = 32'h0040_0200;
        add("eret_over_mispredict", t, mk_out(4'd5, 4'b0000, 3'b111, 0, 5'd0, 0, t.tgt_pc));
        t = in_idle(); t.tgt_pc = 32'h0040_0100; t.mem_read = 1; t.rd = 5'd3; t.rs = 5'd3; t.jump = 1;
        add("mispredict_over_load_use", t, mk_out(4'd3, 4'b0000, 3'b110, 0, 5'd0, 1, t.tgt_pc));
        t = in_idle(); t.mem_read = 1; t.rd = 5'd31; t.rt = 5'd31; t.jump = 1;
        add("load_use_over_jump", t, mk_out(4'd0, 4'b1100, 3'b010, 0, 5'd0, 0, t.tgt_pc));
        t = in_idle(); t.mem_stall = 1; t.tgt_pc = 32'h0040_0100; t.jump = 1; t.eret = 1;
        add("mem_stall_over_all", t, mk_out(4'd0, 4'b1111, 3'b000, 0, 5'd0, 0, t.tgt_pc));

        foreach (vecs[i]) step(vecs[i].name, vecs[i].inp, vecs[i].exp);

        // Syscall and interrupt together: syscall first, interrupt next cycle.
        t = in_idle(); t.syscall = 1; t.cp0_intr = 1; t.tgt_pc = 32'h0040_0020;
        step("sys_intr_same_cycle", t, mk_out(4'd4, 4'b0000, 3'b111, 1, 5'd8, 0, 32'h0040_0020));
        t = in_idle(); t.tgt_pc = 32'h0040_0040;
        step("pending_intr_taken", t, mk_out(4'd4, 4'b0000, 3'b111, 1, 5'd0, 0, 32'h0040_0040));
        t = in_idle();
        step("pending_cleared", t, none);

        // Interrupt pulse under mem_stall is deferred to the first free cycle.
        t = in_idle(); t.mem_stall = 1; t.cp0_intr = 1;
        step("intr_under_stall", t, mk_out(4'd0, 4'b1111, 3'b000, 0, 5'd0, 0, t.tgt_pc));
        t = in_idle(); t.mem_stall = 1;
        step("stall_holds_pending", t, mk_out(4'd0, 4'b1111, 3'b000, 0, 5'd0, 0, t.tgt_pc));
        t = in_idle(); t.tgt_pc = 32'h0040_0050;
        step("deferred_intr_taken", t, mk_out(4'd4, 4'b0000, 3'b111, 1, 5'd0, 0, 32'h0040_0050));
        t = in_idle();
        step("deferred_cleared", t, none);

        // Async reset mid-stall clears pending with no clock edge in between.
        t = in_idle(); t.mem_stall = 1; t.cp0_intr = 1;
        step("stall_sets_pending", t, mk_out(4'd0, 4'b1111, 3'b000, 0, 5'd0, 0, t.tgt_pc));
        @(posedge clk);
        #1;
        t = in_idle(); t.mem_stall = 1;
        drive(t, mk_out(4'd0, 4'b0000, 3'b000, 0, 5'd0, 0, t.tgt_pc));
        rst = 1'b1;
        #1;
        check("async_reset_mid_stall");
        drive(in_idle(), none);
        rst = 1'b0;
        #1;
        check("pending_cleared_by_reset");

        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: got %0d leftover entries want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
